// File: rtl/fmv_prefetch_pkg.sv
// fmv_prefetch_pkg: shared definitions for the FMV sequential word prefetcher.
//   FP_DEPTH   default FIFO depth in words
//   FP_AW      default cartridge word-address width
//   fp_state_e prefetcher FSM states
package fmv_prefetch_pkg;

    localparam int unsigned FP_DEPTH = 16;
    localparam int unsigned FP_AW    = 23;

    typedef enum logic [1:0] {
        FpIdle  = 2'd0,
        FpFetch = 2'd1,
        FpAbort = 2'd2
    } fp_state_e;

endpackage

// File: rtl/fmv_prefetch_fifo.sv
// fmv_prefetch_fifo: synchronous 16-bit FIFO with a registered head word.
//   clk, rst  clock and synchronous active-high reset
//   push, din write din at the tail (ignored when full unless popping)
//   pop       drop the head word (ignored when empty)
//   flush     empty the FIFO; overrides push and pop
//   dout      registered head word, undefined while level = 0
//   level     current occupancy, 0..DEPTH
module fmv_prefetch_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [15:0]              din,
    output logic [15:0]              dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d, count_after_pop;
    logic [15:0]   dout_q, dout_d;
    logic          push_ok, pop_ok;

    assign pop_ok          = pop && (count_q != '0);
    assign push_ok         = push && ((count_q != (PW+1)'(DEPTH)) || pop_ok);
    assign count_after_pop = count_q - (PW+1)'(pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_ok);
            wr_ptr_d = wr_ptr_q + PW'(push_ok);
            count_d  = count_after_pop + (PW+1)'(push_ok);
            // The new head is the word being written this cycle when nothing older remains;
            // the array still holds the old contents here, so bypass din.
            if (push_ok && (count_after_pop == '0)) begin
                dout_d = din;
            end else begin
                dout_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign level = count_q;

endmodule

// File: rtl/fmv_prefetch.sv
// fmv_prefetch: streams a contiguous run of 16-bit cartridge words into a FIFO ahead of
// the FMV mapper so data-port reads never stall.
//   start/base_addr/len  begin a new stream (flushes the FIFO, clears underrun)
//   mem_req/mem_addr     single outstanding fetch, held stable until mem_ack
//   mem_ack/mem_dat      fetch completion, data valid in the ack cycle
//   rd_pop/rd_dat        consumer pop and registered head word
//   rd_valid/level       FIFO non-empty flag and occupancy
//   busy                 stream still fetching (or draining an aborted request)
//   underrun             sticky: pop seen while empty
module fmv_prefetch
    import fmv_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = FP_DEPTH,
    parameter int unsigned AW    = FP_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    input  logic [15:0]            len,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_dat,
    input  logic                   rd_pop,
    output logic [15:0]            rd_dat,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   underrun
);

    localparam int unsigned   LW     = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] DepthL = LW'(DEPTH);

    fp_state_e     state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [15:0]   remain_q, remain_d;
    logic [15:0]   lat_len_q, lat_len_d;
    logic          underrun_q, underrun_d;

    logic          fifo_push, fifo_pop, fifo_flush;
    logic [LW-1:0] fifo_level, level_next;
    logic          room;

    // start flushes, so any same-cycle push or pop is moot.
    assign fifo_flush = start;
    assign fifo_push  = !start && (state_q == FpFetch) && mem_req_q && mem_ack;
    assign fifo_pop   = !start && rd_pop && (fifo_level != '0);
    assign level_next = fifo_level + LW'(fifo_push) - LW'(fifo_pop);
    // Request gating looks at next-cycle occupancy so a push never lands on a full FIFO.
    assign room       = level_next < DepthL;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        lat_addr_d = lat_addr_q;
        lat_len_d  = lat_len_q;
        underrun_d = underrun_q;

        if (start) begin
            underrun_d = 1'b0;
            if (mem_req_q && !mem_ack) begin
                // A request is in flight: let it finish, discard its data, then restart.
                state_d    = FpAbort;
                lat_addr_d = base_addr;
                lat_len_d  = len;
            end else begin
                addr_d    = base_addr;
                remain_d  = len;
                state_d   = (len != '0) ? FpFetch : FpIdle;
                mem_req_d = (len != '0);
            end
        end else begin
            if (rd_pop && (fifo_level == '0)) begin
                underrun_d = 1'b1;
            end
            case (state_q)
                FpFetch: begin
                    if (mem_req_q) begin
                        if (mem_ack) begin
                            addr_d   = addr_q + AW'(1);
                            remain_d = remain_q - 16'd1;
                            if (remain_q == 16'd1) begin
                                state_d   = FpIdle;
                                mem_req_d = 1'b0;
                            end else begin
                                mem_req_d = room;
                            end
                        end
                    end else begin
                        mem_req_d = (remain_q != '0) && room;
                    end
                end
                FpAbort: begin
                    if (mem_ack) begin
                        addr_d    = lat_addr_q;
                        remain_d  = lat_len_q;
                        state_d   = (lat_len_q != '0) ? FpFetch : FpIdle;
                        mem_req_d = (lat_len_q != '0);
                    end
                end
                default: begin
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FpIdle;
            mem_req_q  <= 1'b0;
            addr_q     <= '0;
            remain_q   <= '0;
            lat_addr_q <= '0;
            lat_len_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            lat_addr_q <= lat_addr_d;
            lat_len_q  <= lat_len_d;
            underrun_q <= underrun_d;
        end
    end

    fmv_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (mem_dat),
        .dout  (rd_dat),
        .level (fifo_level)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = addr_q;
    assign level    = fifo_level;
    assign rd_valid = (fifo_level != '0);
    assign busy     = (state_q != FpIdle);
    assign underrun = underrun_q;

endmodule
